// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM responder: command encodings, mode-register
// fields, error codes and the burst column-wrap helper.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_LMR   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BST   = 3'b110,
    CMD_NOP   = 3'b111
  } cmd_e;

  localparam int MODE_BL_LSB = 0;
  localparam int MODE_BL_MSB = 2;
  localparam int MODE_BT_BIT = 3;
  localparam int MODE_CL_LSB = 4;
  localparam int MODE_CL_MSB = 6;

  localparam logic [2:0] BL_MAX_CODE = 3'b011;
  localparam logic [2:0] CL_CODE_2   = 3'b010;
  localparam logic [2:0] CL_CODE_3   = 3'b011;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_CLOSED_BANK  = 3'd1,
    ERR_DOUBLE_ACT   = 3'd2,
    ERR_NO_MODE      = 3'd3,
    ERR_BAD_MODE     = 3'd4,
    ERR_REFRESH_OPEN = 3'd5
  } err_e;

  typedef enum logic [1:0] {
    ENG_IDLE,
    ENG_READ,
    ENG_WRITE
  } eng_e;

  function automatic logic mode_legal(input logic [6:0] m);
    return (m[MODE_BL_MSB:MODE_BL_LSB] <= BL_MAX_CODE) && !m[MODE_BT_BIT] &&
           ((m[MODE_CL_MSB:MODE_CL_LSB] == CL_CODE_2) ||
            (m[MODE_CL_MSB:MODE_CL_LSB] == CL_CODE_3));
  endfunction

  function automatic logic [2:0] bl_mask(input logic [1:0] code);
    return 3'((4'd1 << code) - 4'd1);
  endfunction

  // The beat offset wraps inside the burst-aligned block of the start column.
  function automatic logic [9:0] beat_col(input logic [9:0] col, input logic [2:0] beat,
                                          input logic [2:0] mask);
    logic [9:0] m;
    m = {7'd0, mask};
    return (col & ~m) | ((col + {7'd0, beat}) & m);
  endfunction

endpackage

// File: rtl/sdram_mem_array.sv
// Single-port synchronous RAM with two byte-lane write enables and a
// registered read; the output holds while en is low.
module sdram_mem_array
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we && be[0]) mem[addr][7:0]  <= wdata[7:0];
      if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sdram_responder.sv
// Memory-side SDRAM model: decodes commands, tracks open rows and the mode
// register, runs read/write bursts and returns read data after CAS latency.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4
) (
  input  logic        DDR_CLK,
  input  logic        RST_N,
  input  logic        CKE,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [1:0]  BA,
  input  logic [12:0] ADDR,
  input  logic [1:0]  DM,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        RVALID,
  output logic        ERR,
  output logic [2:0]  ERR_CODE
);

  localparam int AW = 2 + ROW_BITS + COL_BITS;

  cmd_e                cmd;
  logic [3:0]          bank_open;
  logic [12:0]         open_row [4];
  logic                mode_valid;
  logic [1:0]          mode_bl;
  logic                mode_cl3;

  eng_e                eng_state;
  logic [1:0]          eng_bank;
  logic [ROW_BITS-1:0] eng_row;
  logic [9:0]          eng_col;
  logic [2:0]          eng_beat;
  logic [2:0]          eng_mask;

  logic                s0_valid;
  logic                s1_valid;
  logic [15:0]         s1_data;

  logic                rw_ok;
  logic                bst;
  logic                eng_go;
  logic                mem_en;
  logic                mem_we;
  logic                read_issue;
  logic [9:0]          col_k;
  logic [AW-1:0]       mem_addr;
  logic [15:0]         mem_rdata;

  assign cmd = cmd_e'({RAS, CAS, WE});

  // A valid READ/WRITE issues beat 0 straight from the command bus; later
  // beats come from the latched engine state unless a command preempts them.
  assign rw_ok      = CKE && (cmd == CMD_READ || cmd == CMD_WRITE) && mode_valid && bank_open[BA];
  assign bst        = CKE && (cmd == CMD_BST);
  assign eng_go     = CKE && (eng_state != ENG_IDLE) && !rw_ok && !bst;
  assign mem_en     = rw_ok || eng_go;
  assign mem_we     = rw_ok ? (cmd == CMD_WRITE) : (eng_state == ENG_WRITE);
  assign read_issue = mem_en && !mem_we;
  assign col_k      = beat_col(eng_col, eng_beat, eng_mask);
  assign mem_addr   = rw_ok ? {BA, open_row[BA][ROW_BITS-1:0], ADDR[COL_BITS-1:0]}
                            : {eng_bank, eng_row, col_k[COL_BITS-1:0]};

  sdram_mem_array #(.ADDR_W(AW)) u_mem (
    .clk   (DDR_CLK),
    .en    (mem_en),
    .we    (mem_we),
    .be    (~DM),
    .addr  (mem_addr),
    .wdata (WDATA),
    .rdata (mem_rdata)
  );

  always_ff @(posedge DDR_CLK) begin
    if (!RST_N) begin
      bank_open  <= '0;
      mode_valid <= 1'b0;
      mode_bl    <= '0;
      mode_cl3   <= 1'b0;
      eng_state  <= ENG_IDLE;
      eng_bank   <= '0;
      eng_row    <= '0;
      eng_col    <= '0;
      eng_beat   <= '0;
      eng_mask   <= '0;
      s0_valid   <= 1'b0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      RDATA      <= '0;
      RVALID     <= 1'b0;
      ERR        <= 1'b0;
      ERR_CODE   <= ERR_NONE;
    end else if (CKE) begin
      ERR      <= 1'b0;
      ERR_CODE <= ERR_NONE;
      case (cmd)
        CMD_LMR: begin
          if (mode_legal(ADDR[6:0])) begin
            mode_valid <= 1'b1;
            mode_bl    <= ADDR[MODE_BL_LSB+1:MODE_BL_LSB];
            mode_cl3   <= ADDR[MODE_CL_LSB];
          end else begin
            ERR      <= 1'b1;
            ERR_CODE <= ERR_BAD_MODE;
          end
        end
        CMD_ACT: begin
          if (bank_open[BA]) begin
            ERR      <= 1'b1;
            ERR_CODE <= ERR_DOUBLE_ACT;
          end else begin
            bank_open[BA] <= 1'b1;
            open_row[BA]  <= ADDR;
          end
        end
        CMD_PRE: begin
          if (ADDR[10]) bank_open <= '0;
          else          bank_open[BA] <= 1'b0;
        end
        CMD_REF: begin
          if (|bank_open) begin
            ERR      <= 1'b1;
            ERR_CODE <= ERR_REFRESH_OPEN;
          end
        end
        CMD_READ, CMD_WRITE: begin
          if (!bank_open[BA]) begin
            ERR      <= 1'b1;
            ERR_CODE <= ERR_CLOSED_BANK;
          end else if (!mode_valid) begin
            ERR      <= 1'b1;
            ERR_CODE <= ERR_NO_MODE;
          end
        end
        default: ;
      endcase

      if (rw_ok) begin
        eng_state <= (bl_mask(mode_bl) == 3'd0) ? ENG_IDLE
                   : (cmd == CMD_WRITE) ? ENG_WRITE : ENG_READ;
        eng_bank  <= BA;
        eng_row   <= open_row[BA][ROW_BITS-1:0];
        eng_col   <= ADDR[9:0];
        eng_beat  <= 3'd1;
        eng_mask  <= bl_mask(mode_bl);
      end else if (bst) begin
        eng_state <= ENG_IDLE;
      end else if (eng_go) begin
        eng_beat <= eng_beat + 3'd1;
        if (eng_beat == eng_mask) eng_state <= ENG_IDLE;
      end

      // RAM output is stage 0; CL=3 adds one more register before the port.
      s0_valid <= read_issue;
      s1_valid <= s0_valid;
      s1_data  <= mem_rdata;
      RVALID   <= mode_cl3 ? s1_valid : s0_valid;
      if (mode_cl3 ? s1_valid : s0_valid)
        RDATA <= mode_cl3 ? s1_data : mem_rdata;
    end else begin
      ERR      <= 1'b0;
      ERR_CODE <= ERR_NONE;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder; outputs are sampled on the falling edge,
// so the value seen after rising edge e is what the controller samples at e+1.
module tb_sdram_responder;

  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_BST = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cke;
  logic        ras, cas, we;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic [1:0]  dm;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid;
  logic        err;
  logic [2:0]  err_code;

  int vectors = 0;
  int miscompares = 0;

  sdram_responder dut (
    .DDR_CLK  (clk),
    .RST_N    (rst_n),
    .CKE      (cke),
    .RAS      (ras),
    .CAS      (cas),
    .WE       (we),
    .BA       (ba),
    .ADDR     (addr),
    .DM       (dm),
    .WDATA    (wdata),
    .RDATA    (rdata),
    .RVALID   (rvalid),
    .ERR      (err),
    .ERR_CODE (err_code)
  );

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                                input logic [15:0] wd, input logic [1:0] mask);
    {ras, cas, we} = c;
    ba    = b;
    addr  = a;
    wdata = wd;
    dm    = mask;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic nop();
    apply_stimulus(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic expect_beat(input string tag, input logic v, input logic [15:0] d);
    check_output({tag, ".rvalid"}, {15'd0, rvalid}, {15'd0, v});
    if (v) check_output({tag, ".rdata"}, rdata, d);
  endtask

  task automatic expect_err(input string tag, input logic e, input logic [2:0] code);
    check_output({tag, ".err"}, {15'd0, err}, {15'd0, e});
    if (e) check_output({tag, ".code"}, {13'd0, err_code}, {13'd0, code});
  endtask

  initial begin
    rst_n = 1'b0;
    cke   = 1'b1;
    {ras, cas, we} = C_NOP;
    ba = '0; addr = '0; dm = '0; wdata = '0;
    nop();
    nop();
    check_output("reset.rdata", rdata, 16'h0000);
    check_output("reset.rvalid", {15'd0, rvalid}, 16'd0);
    check_output("reset.err", {15'd0, err}, 16'd0);
    check_output("reset.code", {13'd0, err_code}, 16'd0);
    rst_n = 1'b1;

    // READ with an open bank but no mode programmed -> code 3, no data
    apply_stimulus(C_ACT, 2'd0, 13'd0, 16'd0, 2'b00);
    apply_stimulus(C_RD, 2'd0, 13'd0, 16'd0, 2'b00);
    expect_err("nomode", 1'b1, 3'd3);
    nop();
    expect_err("nomode_pulse", 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      expect_beat("nomode_quiet", 1'b0, 16'h0);
      nop();
    end

    // CL=2 BL=2: write A5A5,1234 at col 2, read back
    apply_stimulus(C_LMR, 2'd0, 13'h021, 16'd0, 2'b00);
    expect_err("lmr021", 1'b0, 3'd0);
    apply_stimulus(C_ACT, 2'd1, 13'd5, 16'd0, 2'b00);
    apply_stimulus(C_WR, 2'd1, 13'd2, 16'hA5A5, 2'b00);
    apply_stimulus(C_NOP, 2'd0, 13'd0, 16'h1234, 2'b00);
    apply_stimulus(C_RD, 2'd1, 13'd2, 16'd0, 2'b00);
    expect_beat("cl2_t1", 1'b0, 16'h0);
    nop();
    expect_beat("cl2_b0", 1'b1, 16'hA5A5);
    nop();
    expect_beat("cl2_b1", 1'b1, 16'h1234);
    nop();
    expect_beat("cl2_end", 1'b0, 16'h0);

    // CL=3 BL=4: cols 4..7 = 1..4, read from col 6 wraps to 3,4,1,2
    apply_stimulus(C_LMR, 2'd0, 13'h032, 16'd0, 2'b00);
    apply_stimulus(C_WR, 2'd1, 13'd4, 16'd1, 2'b00);
    apply_stimulus(C_NOP, 2'd0, 13'd0, 16'd2, 2'b00);
    apply_stimulus(C_NOP, 2'd0, 13'd0, 16'd3, 2'b00);
    apply_stimulus(C_NOP, 2'd0, 13'd0, 16'd4, 2'b00);
    apply_stimulus(C_RD, 2'd1, 13'd6, 16'd0, 2'b00);
    expect_beat("cl3_t1", 1'b0, 16'h0);
    nop();
    expect_beat("cl3_t2", 1'b0, 16'h0);
    nop();
    expect_beat("cl3_b0", 1'b1, 16'd3);
    nop();
    expect_beat("cl3_b1", 1'b1, 16'd4);
    nop();
    expect_beat("cl3_b2", 1'b1, 16'd1);
    nop();
    expect_beat("cl3_b3", 1'b1, 16'd2);
    nop();
    expect_beat("cl3_end", 1'b0, 16'h0);

    // Byte mask: zero cols 8..11, then FFFF with DM=10 on col 8 only
    apply_stimulus(C_WR, 2'd1, 13'd8, 16'h0000, 2'b00);
    for (int i = 0; i < 3; i++) apply_stimulus(C_NOP, 2'd0, 13'd0, 16'h0000, 2'b00);
    apply_stimulus(C_WR, 2'd1, 13'd8, 16'hFFFF, 2'b10);
    for (int i = 0; i < 3; i++) apply_stimulus(C_NOP, 2'd0, 13'd0, 16'hFFFF, 2'b11);
    apply_stimulus(C_RD, 2'd1, 13'd8, 16'd0, 2'b00);
    nop();
    nop();
    expect_beat("dm_b0", 1'b1, 16'h00FF);
    nop();
    expect_beat("dm_b1", 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) nop();

    // Protocol violations
    apply_stimulus(C_RD, 2'd3, 13'd0, 16'd0, 2'b00);
    expect_err("closed_bank", 1'b1, 3'd1);
    for (int i = 0; i < 4; i++) begin
      nop();
      expect_beat("closed_quiet", 1'b0, 16'h0);
    end
    apply_stimulus(C_ACT, 2'd1, 13'd9, 16'd0, 2'b00);
    expect_err("double_act", 1'b1, 3'd2);
    apply_stimulus(C_LMR, 2'd0, 13'h024, 16'd0, 2'b00);
    expect_err("bad_mode", 1'b1, 3'd4);
    apply_stimulus(C_REF, 2'd0, 13'd0, 16'd0, 2'b00);
    expect_err("refresh_open", 1'b1, 3'd5);

    // CL=3 BL=8: cols 0..7 = 10h..17h; read then BURST TERMINATE next cycle
    apply_stimulus(C_LMR, 2'd0, 13'h033, 16'd0, 2'b00);
    apply_stimulus(C_WR, 2'd1, 13'd0, 16'h0010, 2'b00);
    for (int i = 1; i < 8; i++) apply_stimulus(C_NOP, 2'd0, 13'd0, 16'(16'h0010 + i), 2'b00);
    apply_stimulus(C_RD, 2'd1, 13'd0, 16'd0, 2'b00);
    apply_stimulus(C_BST, 2'd0, 13'd0, 16'd0, 2'b00);
    expect_beat("bst_t1", 1'b0, 16'h0);
    nop();
    expect_beat("bst_b0", 1'b1, 16'h0010);
    nop();
    expect_beat("bst_end", 1'b0, 16'h0);
    nop();
    expect_beat("bst_end2", 1'b0, 16'h0);

    // CKE low for two edges after beat 0 is out: output and burst freeze
    apply_stimulus(C_RD, 2'd1, 13'd0, 16'd0, 2'b00);
    nop();
    expect_beat("cke_t1", 1'b0, 16'h0);
    nop();
    expect_beat("cke_b0", 1'b1, 16'h0010);
    cke = 1'b0;
    apply_stimulus(C_RD, 2'd3, 13'd0, 16'd0, 2'b00);
    expect_beat("cke_hold1", 1'b1, 16'h0010);
    expect_err("cke_noerr", 1'b0, 3'd0);
    nop();
    expect_beat("cke_hold2", 1'b1, 16'h0010);
    cke = 1'b1;
    for (int k = 1; k < 8; k++) begin
      nop();
      expect_beat("cke_beat", 1'b1, 16'(16'h0010 + k));
    end
    nop();
    expect_beat("cke_end", 1'b0, 16'h0);

    // Reset mid-read clears RVALID and closes banks
    apply_stimulus(C_RD, 2'd1, 13'd0, 16'd0, 2'b00);
    nop();
    nop();
    expect_beat("rst_b0", 1'b1, 16'h0010);
    rst_n = 1'b0;
    nop();
    expect_beat("rst_cleared", 1'b0, 16'h0);
    rst_n = 1'b1;
    apply_stimulus(C_RD, 2'd1, 13'd0, 16'd0, 2'b00);
    expect_err("rst_closed", 1'b1, 3'd1);
    for (int i = 0; i < 4; i++) begin
      nop();
      expect_beat("rst_quiet", 1'b0, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
